sae_stream_ctrl: RTL

Byte-stream front end for the `sae` core. It buffers incoming characters in a small FIFO and issues them one at a time to `sae` using a held mode and key. For each byte it waits for `output_ready` or an error flag, then returns the result byte plus an error code on a valid/ready output port. It sits directly upstream of `sae`, driving all of its inputs and consuming all of its outputs.

---
 rtl/sae_stream_ctrl_if.sv | 21 ++
 rtl/sae_stream_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sae_stream_ctrl_if.sv
// Byte-stream handshake bundle for sae_stream_ctrl: byte input port and result output port.
// The controller uses the slave modport; the upstream/downstream side uses master.
interface sae_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/sae_stream_ctrl.sv
// sae_stream_ctrl: byte FIFO plus a one-transaction-in-flight IDLE/ISSUE/WAIT sequencer for the sae core.
// Optional WAIT timeout is compiled in when SAE_STREAM_TIMEOUT_EN is defined.
module sae_stream_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_mode,
  input  logic [7:0]              cfg_key,
  sae_stream_ctrl_if.slave        strm,
  output logic [1:0]              sae_mode,
  output logic [7:0]              sae_data_input,
  output logic [7:0]              sae_key_input,
  output logic                    sae_inputs_valid,
  input  logic [7:0]              sae_data_output,
  input  logic                    sae_output_ready,
  input  logic                    sae_err_invalid_ptxt_char,
  input  logic                    sae_err_invalid_seckey,
  input  logic                    sae_err_invalid_ctxt_char,
  output logic                    busy,
  output logic [7:0]              err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sae_stream_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    cfg_mode_q, cfg_mode_d;
  logic [7:0]    cfg_key_q, cfg_key_d;
  logic [1:0]    sae_mode_q, sae_mode_d;
  logic [7:0]    sae_data_q, sae_data_d;
  logic [7:0]    sae_key_q, sae_key_d;
  logic          sae_valid_q, sae_valid_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [3:0]    out_err_q, out_err_d;
  logic [7:0]    err_count_q, err_count_d;
`ifdef SAE_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic       full, empty, push, pop;
  logic       sae_resp, capture;
  logic [7:0] cap_data;
  logic [3:0] cap_err;

  assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  assign strm.in_ready = !rst && !full;
  assign push          = strm.in_valid && strm.in_ready;
  assign sae_resp      = sae_output_ready | sae_err_invalid_ptxt_char |
                         sae_err_invalid_seckey | sae_err_invalid_ctxt_char;

  always_comb begin
    state_d     = state_q;
    cfg_mode_d  = cfg_mode_q;
    cfg_key_d   = cfg_key_q;
    sae_mode_d  = sae_mode_q;
    sae_data_d  = sae_data_q;
    sae_key_d   = sae_key_q;
    sae_valid_d = sae_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    pop         = 1'b0;
    capture     = 1'b0;
    cap_data    = 8'h00;
    cap_err     = 4'b0000;
`ifdef SAE_STREAM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    if (cfg_we && state_q == IDLE) begin
      cfg_mode_d = cfg_mode;
      cfg_key_d  = cfg_key;
    end

    if (out_valid_q && strm.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // A pending result blocks the next issue so results never overlap.
        if (!empty && !out_valid_q && cfg_mode_q != 2'b00) begin
          pop         = 1'b1;
          state_d     = ISSUE;
          sae_mode_d  = cfg_mode_q;
          sae_key_d   = cfg_key_q;
          sae_data_d  = fifo_mem[rd_ptr_q];
          sae_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        sae_valid_d = 1'b0;
        state_d     = WAIT;
`ifdef SAE_STREAM_TIMEOUT_EN
        wait_cnt_d  = TW'(1);
`endif
      end
      WAIT: begin
        if (sae_resp) begin
          capture  = 1'b1;
          cap_data = sae_output_ready ? sae_data_output : 8'h00;
          cap_err  = {1'b0, sae_err_invalid_ctxt_char, sae_err_invalid_seckey,
                      sae_err_invalid_ptxt_char};
        end
`ifdef SAE_STREAM_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT_CYCLES)) begin
          capture  = 1'b1;
          cap_data = 8'h00;
          cap_err  = 4'b1000;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
        if (capture) begin
          state_d     = IDLE;
          sae_mode_d  = 2'b00;
          sae_data_d  = 8'h00;
          sae_key_d   = 8'h00;
          out_valid_d = 1'b1;
          out_data_d  = cap_data;
          out_err_d   = cap_err;
          if (cap_err != 4'b0000 && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cfg_mode_q  <= 2'b00;
      cfg_key_q   <= 8'h00;
      sae_mode_q  <= 2'b00;
      sae_data_q  <= 8'h00;
      sae_key_q   <= 8'h00;
      sae_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_err_q   <= 4'b0000;
      err_count_q <= 8'h00;
`ifdef SAE_STREAM_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cfg_mode_q  <= cfg_mode_d;
      cfg_key_q   <= cfg_key_d;
      sae_mode_q  <= sae_mode_d;
      sae_data_q  <= sae_data_d;
      sae_key_q   <= sae_key_d;
      sae_valid_q <= sae_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
`ifdef SAE_STREAM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // Storage array carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= strm.in_data;
    end
  end

  assign sae_mode         = sae_mode_q;
  assign sae_data_input   = sae_data_q;
  assign sae_key_input    = sae_key_q;
  assign sae_inputs_valid = sae_valid_q;
  assign strm.out_valid   = out_valid_q;
  assign strm.out_data    = out_data_q;
  assign strm.out_err     = out_err_q;
  assign err_count        = err_count_q;
  assign busy             = (state_q != IDLE) || !empty;
endmodule
